// File: rtl/flex_counter_pkg.sv
// Shared definitions for the up/down flex counter family.
//
// Contents:
//   state_t - counter control state (IDLE, RUN, HALT), 2-bit encoding
package flex_counter_pkg;

  // IDLE: count parked at zero after reset or clear.
  // RUN : counting (or holding with count_enable low).
  // HALT: one-shot terminal count reached; only clear or load leave it.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

endpackage

// File: rtl/updown_flex_counter.sv
// Parametrised up/down rollover counter with parallel load, one-shot mode
// and a single-cycle wrap pulse. Serves as the timing / bit-count engine
// for shift-register, UART-style and timer blocks.
//
// Ports:
//   clk           - system clock, rising edge
//   n_rst         - asynchronous active-low reset
//   clear         - synchronous clear to IDLE (highest priority)
//   count_enable  - advance the count this cycle
//   count_up      - 1 = count up, 0 = count down
//   load          - synchronous load of load_val (below clear)
//   load_val      - value taken on load
//   rollover_val  - terminal/reload value R; 0 disables counting
//   oneshot       - 1 = halt at terminal count, 0 = auto-reload
//   count_out     - registered count
//   rollover_flag - high while count_out equals the terminal value
//   wrap_pulse    - high for the single cycle showing a wrapped value
//   done          - sticky one-shot completion
module updown_flex_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic                    oneshot,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse,
  output logic                    done
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    rollover_q, rollover_d;
  logic                    wrap_q, wrap_d;
  logic                    done_q, done_d;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic                    step_ok;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rollover_q <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rollover_q <= rollover_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = done_q;
    wrap_d   = 1'b0;
    terminal = count_up ? rollover_val : ONE;
    step_ok  = count_enable && (rollover_val != '0) && (state_q != HALT);

    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = IDLE;
    end else if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (step_ok) begin
      state_d = RUN;
      // The >= / <= comparisons also catch counts left outside 1..R by a
      // load or an R change, so the count never runs past either end.
      if (count_up) begin
        if (count_q >= rollover_val) begin
          count_d = ONE;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q <= ONE) begin
          count_d = rollover_val;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
      // Only a step (never a load) can complete a one-shot run.
      if (oneshot && (count_d == terminal)) begin
        state_d = HALT;
        done_d  = 1'b1;
      end
    end

    // Flag is re-evaluated every cycle from the value about to be shown,
    // so it lines up with count_out and follows direction changes.
    rollover_d = (rollover_val != '0) && (count_d == terminal);
  end

  assign count_out     = count_q;
  assign rollover_flag = rollover_q;
  assign wrap_pulse    = wrap_q;
  assign done          = done_q;

endmodule

// File: doc/updown_flex_counter.md
Name: updown_flex_counter

Overview:
Parametrised successor to the team's flex counter. Adds the following to the single-direction rollover counter:
- selectable up/down counting
- synchronous parallel load
- one-shot versus auto-reload mode with a sticky done indication
- a single-cycle wrap pulse alongside the level rollover flag
Used as the timing and bit-count engine in shift-register, UART-style and timer blocks.

Parameters:
NUM_CNT_BITS, 4, width of count, load and rollover values (min 2)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear to idle, highest priority
count_enable  input  1  advance count this cycle
count_up  input  1  1 = count up, 0 = count down; sampled every cycle
load  input  1  synchronous load of load_val, priority below clear
load_val  input  NUM_CNT_BITS  value loaded on load
rollover_val  input  NUM_CNT_BITS  terminal/reload value R; 0 disables counting
oneshot  input  1  1 = halt at terminal count, 0 = auto-reload
count_out  output  NUM_CNT_BITS  registered count
rollover_flag  output  1  registered; high while count_out equals terminal value of current direction
wrap_pulse  output  1  registered; high for exactly the cycle count_out first shows the wrapped value
done  output  1  registered; sticky one-shot completion

Behaviour:
- Reset (n_rst low, async): count_out=0, rollover_flag=0, wrap_pulse=0, done=0, state=IDLE.
- States:
  - IDLE: count 0, after reset or clear.
  - RUN: counting.
  - HALT: one-shot terminal reached.
- Per-edge priority: clear > load > count.
- clear: count_out=0, done=0, state to IDLE.
- load: count_out=load_val, done=0, state to RUN. count_enable is ignored that cycle.
- Count step in IDLE/RUN, when count_enable=1 and R!=0; IDLE moves to RUN on the first step:
  - Up: if count_out >= R, next=1 and wrap; else next=count_out+1.
  - Down: if count_out <= 1, next=R and wrap; else next=count_out-1.
  - So up sequence is 0,1..R,1..; down from 0 is R,R-1..1,R..
  - Arithmetic is NUM_CNT_BITS-wide unsigned; no overflow is possible given the >= / <= rules.
- R==0: count_enable is ignored; count holds; rollover_flag=0, wrap_pulse=0.
- Terminal value: R when counting up, 1 when counting down.
- rollover_flag is registered from (next count == terminal for current count_up). It therefore aligns with count_out, is re-evaluated every cycle even when holding, and tracks a direction change with one cycle of latency.
- wrap_pulse=1 only in the cycle following an edge where a wrap occurred; otherwise 0.
- One-shot (oneshot=1, sampled at the stepping edge):
  - When a step produces the terminal value, state goes to HALT and done=1 from the same edge.
  - In HALT, count_out holds and count_enable is ignored. Only clear or load leave HALT.
  - Deasserting oneshot while in HALT has no effect.
  - A load of a value equal to the terminal does not set done; only a step does.
- Auto-reload (oneshot=0): never enters HALT; done stays 0.
- R changed mid-count takes effect immediately. A count above the new R wraps to 1 on the next up step.
- Loading a value > R then counting down decrements normally to 1.
- Reset asserted mid-operation overrides everything asynchronously.
- Latency: all outputs are registered, one cycle after the causing input edge.

Decomposition:
- Shared package flex_counter_pkg: state enum typedef (IDLE, RUN, HALT), 2-bit encoding.
- Single module. Next-count/terminal logic is one always_comb. No sub-module is warranted.

Test Plan:
1. R=5, up, enable continuously from reset -> count 1,2,3,4,5,1; rollover_flag high while 5; wrap_pulse high on the cycle count=1 after the 5.
2. R=5, down, enable from reset -> count 5,4,3,2,1,5; rollover_flag high while count=1; wrap_pulse high when 5 reappears.
3. R=3, oneshot=1, up, enable held -> 1,2,3 then holds at 3; done=1 from the edge showing 3 and stays high; load_val=0 with load -> count=0, done=0, counting resumes.
4. Count at 4 (R=9); same cycle clear=1, load=1 (load_val=7), enable=1 -> count=0, state IDLE; next cycle load only -> count=7 with enable ignored.
5. R=0 with enable held for 10 cycles -> count stays 0, flags 0. Then R=4 mid-run with count=6 and up step -> count=1, wrap_pulse=1.
6. Reset pulse asserted asynchronously mid-count (count=3, done=1) -> all outputs 0 before the next clock edge; state IDLE.
